// File: rtl/arb_pkg.sv
// arb_pkg: shared state encodings, grant constants and helpers for the round-robin arbiter
package arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_e;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT0     = 2'b01;
  localparam logic [1:0] GNT1     = 2'b10;
  function automatic state_e st_of(input logic s);
    return s ? ST_G1 : ST_G0;
  endfunction
  function automatic logic [1:0] gnt_of(input state_e st);
    return st == ST_G0 ? GNT0 : st == ST_G1 ? GNT1 : GNT_NONE;
  endfunction
endpackage

// File: rtl/mux_2_1.sv
// mux_2_1: single-bit 2:1 multiplexer, in[0] when s=0, in[1] when s=1
module mux_2_1 (
  input  logic       s,
  input  logic [1:0] in,
  output logic       y
);
  assign y = in[s];
endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: packet-granular round-robin arbiter steering two valid/ready streams onto one
module mux2_rr_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        in_valid,
  input  logic [1:0]        in_last,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  output logic [1:0]        in_ready,
  output logic              out_valid,
  output logic              out_last,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        grant,
  output logic              err_pulse
);
  localparam int CW = $clog2(MAX_BEATS);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);
  state_e        state_q;
  logic          sel_q, prio_q, err_q;
  logic [CW-1:0] cnt_q;
  logic          busy, mux_valid, mux_last, acc, rel, oth, pick;
  assign busy = state_q != ST_IDLE;
  assign oth  = ~sel_q;
  assign pick = &in_valid ? prio_q : in_valid[1];
  for (genvar i = 0; i < DATA_W; i++) begin : g_data
    mux_2_1 u_data (.s(sel_q), .in({in_data1[i], in_data0[i]}), .y(out_data[i]));
  end
  mux_2_1 u_valid (.s(sel_q), .in(in_valid), .y(mux_valid));
  mux_2_1 u_last  (.s(sel_q), .in(in_last),  .y(mux_last));
  assign out_valid = busy & mux_valid;
  assign out_last  = busy & mux_last;
  assign in_ready  = {state_q == ST_G1 & out_ready, state_q == ST_G0 & out_ready};
  assign grant     = gnt_of(state_q);
  assign err_pulse = err_q;
  assign acc       = out_valid & out_ready;
  // a packet ends on its last beat or when the watchdog limit is reached without one
  assign rel       = acc & (out_last | cnt_q == CNT_LAST);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= rel & ~out_last;
      if (!busy) begin
        if (|in_valid) begin
          state_q <= st_of(pick);
          sel_q   <= pick;
          cnt_q   <= '0;
        end
      end else if (rel) begin
        prio_q <= oth;
        cnt_q  <= '0;
        if (in_valid[oth]) begin
          state_q <= st_of(oth);
          sel_q   <= oth;
        end else begin
          state_q <= ST_IDLE;
        end
      end else if (acc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: vector table, directed corner sequences and randomized traffic against a packet-level model
module tb_mux2_rr_arbiter;
  localparam int MB = 4;
  logic       clk = 1'b0, rst = 1'b1, out_ready = 1'b0;
  logic [1:0] in_valid = '0, in_last = '0, in_ready, grant;
  logic [7:0] in_data0 = '0, in_data1 = '0, out_data;
  logic       out_valid, out_last, err_pulse;
  int checks = 0, errors = 0;
  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;
  beat_t      q0[$], q1[$];
  logic [7:0] rx[$];
  logic [1:0] en = 2'b11;
  int m_owner = -1, m_prio = 0, m_beats = 0;
  logic m_err = 1'b0;
  int n_err = 0, n_pk0 = 0, n_acc1 = 0;

  mux2_rr_arbiter #(.DATA_W(8), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
    .in_data0(in_data0), .in_data1(in_data1), .in_ready(in_ready),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data),
    .out_ready(out_ready), .grant(grant), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pre(input logic r, input logic rs);
    @(negedge clk);
    rst       = rs;
    out_ready = r;
    in_valid  = {en[1] && q1.size() > 0, en[0] && q0.size() > 0};
    in_data0  = q0.size() > 0 ? q0[0].d : 8'($urandom);
    in_data1  = q1.size() > 0 ? q1[0].d : 8'($urandom);
    in_last   = {q1.size() > 0 ? q1[0].l : 1'($urandom), q0.size() > 0 ? q0[0].l : 1'($urandom)};
    #1;
  endtask

  // compare against the model, account accepted beats, advance the model, then clock
  task automatic post();
    logic [1:0] eg;
    logic       eov;
    int         o;
    eg  = m_owner == 0 ? 2'b01 : m_owner == 1 ? 2'b10 : 2'b00;
    eov = m_owner >= 0 && in_valid[m_owner];
    chk("grant", grant, eg);
    chk("out_valid", out_valid, eov);
    chk("in_ready", in_ready, out_ready ? eg : 2'b00);
    chk("err_pulse", err_pulse, m_err);
    if (eov) begin
      chk("out_data", out_data, m_owner == 1 ? in_data1 : in_data0);
      chk("out_last", out_last, in_last[m_owner]);
    end
    if (err_pulse) n_err++;
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (out_valid && out_ready) begin
        rx.push_back(out_data);
        if (grant == 2'b10) n_acc1++;
        if (grant == 2'b01 && out_last) n_pk0++;
      end
      if (in_valid[0] && in_ready[0] && q0.size() > 0) void'(q0.pop_front());
      if (in_valid[1] && in_ready[1] && q1.size() > 0) void'(q1.pop_front());
    end
    if (rst) begin
      m_owner = -1;
      m_prio  = 0;
      m_beats = 0;
      m_err   = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_owner < 0) begin
        if (in_valid != 2'b00) begin
          m_owner = in_valid == 2'b11 ? m_prio : (in_valid[1] ? 1 : 0);
          m_beats = 0;
        end
      end else if (eov && out_ready) begin
        m_beats++;
        if (in_last[m_owner] || m_beats == MB) begin
          o       = 1 - m_owner;
          m_err   = !in_last[m_owner];
          m_prio  = o;
          m_owner = in_valid[o] ? o : -1;
          m_beats = 0;
        end
      end
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    en = 2'b11;
    pre(1'b1, 1'b1);
    post();
    rx.delete();
    n_err  = 0;
    n_pk0  = 0;
    n_acc1 = 0;
  endtask

  task automatic push_pkt(input int src, input int len);
    for (int b = 0; b < len; b++) begin
      if (src == 0) q0.push_back('{8'($urandom), b == len - 1});
      else q1.push_back('{8'($urandom), b == len - 1});
    end
  endtask

  typedef struct {
    logic       rs;
    logic [1:0] v, l;
    logic [7:0] d0, d1;
    logic       r;
    logic [1:0] eg;
    logic       eov;
    logic [7:0] eod;
    logic [1:0] eir;
  } vec_t;

  vec_t       tbl[11];
  logic [7:0] exp5[7];
  int         base, gap;
  logic       seen1;

  initial begin
    tbl[0]  = '{1'b1, 2'b11, 2'b00, 8'hA1, 8'hB1, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = '{1'b0, 2'b11, 2'b00, 8'hA1, 8'hB1, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00};
    tbl[4]  = '{1'b0, 2'b11, 2'b00, 8'hA1, 8'hB1, 1'b1, 2'b01, 1'b1, 8'hA1, 2'b01};
    tbl[5]  = '{1'b0, 2'b11, 2'b00, 8'hA2, 8'hB1, 1'b1, 2'b01, 1'b1, 8'hA2, 2'b01};
    tbl[6]  = '{1'b0, 2'b11, 2'b01, 8'hA3, 8'hB1, 1'b1, 2'b01, 1'b1, 8'hA3, 2'b01};
    tbl[7]  = '{1'b0, 2'b10, 2'b00, 8'h00, 8'hB1, 1'b1, 2'b10, 1'b1, 8'hB1, 2'b10};
    tbl[8]  = '{1'b0, 2'b10, 2'b00, 8'h00, 8'hB2, 1'b1, 2'b10, 1'b1, 8'hB2, 2'b10};
    tbl[9]  = '{1'b0, 2'b10, 2'b10, 8'h00, 8'hB3, 1'b1, 2'b10, 1'b1, 8'hB3, 2'b10};
    tbl[10] = '{1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00};
    pre(1'b1, 1'b1);
    post();
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      rst       = tbl[k].rs;
      in_valid  = tbl[k].v;
      in_last   = tbl[k].l;
      in_data0  = tbl[k].d0;
      in_data1  = tbl[k].d1;
      out_ready = tbl[k].r;
      #1;
      chk($sformatf("tbl%0d_grant", k), grant, tbl[k].eg);
      chk($sformatf("tbl%0d_valid", k), out_valid, tbl[k].eov);
      chk($sformatf("tbl%0d_ready", k), in_ready, tbl[k].eir);
      if (tbl[k].eov) chk($sformatf("tbl%0d_data", k), out_data, tbl[k].eod);
      post();
    end
    do_reset();
    for (int i = 0; i < 12; i++) q0.push_back('{8'(8'h30 + i), 1'b1});
    seen1 = 1'b0;
    base  = 0;
    gap   = 99;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) begin
        q1.push_back('{8'h70, 1'b0});
        q1.push_back('{8'h71, 1'b1});
        base = n_pk0;
      end
      pre(1'b1, 1'b0);
      post();
      if (c >= 5 && !seen1 && n_acc1 > 0) begin
        seen1 = 1'b1;
        gap   = n_pk0 - base;
      end
    end
    chk("fair_req1_served", seen1, 1'b1);
    chk("fair_gap", gap <= 1, 1'b1);
    chk("fair_req1_drained", q1.size(), 0);
    do_reset();
    for (int i = 0; i < 4; i++) q0.push_back('{8'(8'hC1 + i), i == 3});
    en = 2'b01;
    for (int c = 0; c < 20; c++) begin
      pre(c % 2 == 0, 1'b0);
      post();
    end
    chk("bp_count", rx.size(), 4);
    for (int i = 0; i < 4 && i < rx.size(); i++) chk($sformatf("bp_beat%0d", i), rx[i], 8'(8'hC1 + i));
    do_reset();
    for (int i = 0; i < 6; i++) q0.push_back('{8'(8'hD1 + i), 1'b0});
    q1.push_back('{8'hE1, 1'b1});
    exp5 = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hE1, 8'hD5, 8'hD6};
    for (int c = 0; c < 15; c++) begin
      pre(1'b1, 1'b0);
      post();
    end
    chk("wd_count", rx.size(), 7);
    for (int i = 0; i < 7 && i < rx.size(); i++) chk($sformatf("wd_beat%0d", i), rx[i], exp5[i]);
    chk("wd_err_pulses", n_err, 1);
    do_reset();
    for (int i = 0; i < 4; i++) q0.push_back('{8'(8'hF1 + i), i == 3});
    en = 2'b01;
    for (int c = 0; c < 3; c++) begin
      pre(1'b1, 1'b0);
      post();
    end
    pre(1'b1, 1'b1);
    post();
    chk("rstmid_beats", rx.size(), 2);
    q0.push_back('{8'h55, 1'b1});
    q1.push_back('{8'h66, 1'b1});
    en = 2'b11;
    pre(1'b1, 1'b0);
    chk("rstmid_grant", grant, 2'b00);
    chk("rstmid_valid", out_valid, 1'b0);
    post();
    pre(1'b1, 1'b0);
    chk("rstmid_prio", grant, 2'b01);
    post();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom % 4 == 0 && q0.size() < 12) push_pkt(0, int'($urandom_range(1, 6)));
      if ($urandom % 4 == 0 && q1.size() < 12) push_pkt(1, int'($urandom_range(1, 6)));
      en = {$urandom % 4 != 0, $urandom % 4 != 0};
      pre($urandom % 4 != 0, $urandom % 300 == 0);
      post();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
